id_ex_elastic_reg: RTL
======================

Name: id_ex_elastic_reg

Overview:
Parametrised decode-to-execute pipeline register for the RV32 core. It replaces the fixed, always-loading stage register with a valid/ready elastic stage. A 2-entry skid buffer gives a fully registered backpressure path. A flush input inserts bubbles on branch/jump redirect. Sits between the decode stage and the ALU/hazard unit.

Parameters:
DATA_WIDTH, 32, width of each datapath field (rd1, rd2, pc, ext_imm, pc_plus4)
NUM_DATA, 5, number of DATA_WIDTH fields packed in the data bus
REGISTER_WIDTH, 5, register-index width (rs1, rs2, rd)
CTRL_WIDTH, 12, packed control bits (reg_write, result_src[1:0], mem_write, jump, branch, alu_src, byte_op, alu_control[3:0])

Ports:
clk  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
data_d_i  in  NUM_DATA*DATA_WIDTH  packed datapath fields from decode
regs_d_i  in  3*REGISTER_WIDTH  packed {rs1, rs2, rd} from decode
ctrl_d_i  in  CTRL_WIDTH  packed control from decode
valid_d_i  in  1  decode presents an instruction
ready_d_o  out  1  stage can accept; registered
flush_i  in  1  kill all held instructions
data_e_o  out  NUM_DATA*DATA_WIDTH  datapath fields to execute
regs_e_o  out  3*REGISTER_WIDTH  {rs1, rs2, rd} to execute
ctrl_e_o  out  CTRL_WIDTH  control to execute
valid_e_o  out  1  execute slot holds a live instruction
ready_e_i  in  1  execute consumes the slot this cycle
stall_cnt_o  out  32  backpressure cycle counter (optional feature)
flush_cnt_o  out  32  killed-instruction counter (optional feature)

Behaviour:
- Handshake events:
  - fire_in = valid_d_i & ready_d_o
  - fire_out = valid_e_o & ready_e_i
  - Payload is transferred only on a fire event.
- Storage and states:
  - Two entries: MAIN, which drives the *_e_o outputs, and SKID, which is internal.
  - States: EMPTY (no valid entries), FULL (MAIN valid), SKID (MAIN and SKID both valid).
- Transitions:
  - EMPTY: fire_in -> MAIN<=input, go to FULL. Otherwise stay.
  - FULL, fire_in & fire_out: MAIN<=input, stay FULL.
  - FULL, fire_in & !fire_out: SKID<=input, go to SKID, ready_d_o<=0.
  - FULL, !fire_in & fire_out: go to EMPTY.
  - FULL, neither event: hold.
  - SKID, fire_out: MAIN<=SKID, go to FULL, ready_d_o<=1.
  - SKID, no fire_out: hold everything.
- Latency: 1 cycle from fire_in to valid_e_o when the stage is EMPTY or draining. The SKID entry is never bypassed, so ordering is strictly FIFO.
- ready_d_o is a flop: 1 in EMPTY/FULL, 0 in SKID. It does not depend combinationally on ready_e_i.
- Bubble semantics: whenever MAIN becomes invalid (drain to EMPTY, flush, reset), ctrl_e_o and regs_e_o are zero. data_e_o holds its last value.
- Flush:
  - flush_i has priority over every other event.
  - Next state is EMPTY; MAIN and SKID are invalidated; ctrl/regs are zeroed; ready_d_o<=1.
  - Any fire_in in the same cycle is discarded.
  - A fire_out in the same cycle still counts as consumed by execute.
- Reset (asynchronous, active-high, also mid-transfer):
  - State EMPTY, valid_e_o=0, ready_d_o=1.
  - data_e_o, regs_e_o, ctrl_e_o, the SKID contents and both counters are all 0.
- No arithmetic except the counters. Counters wrap modulo 2^32.

Optional Feature:
Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 each cycle with valid_e_o & !ready_e_i & !flush_i.
  - flush_cnt_o increments on a flush_i cycle by the number of valid entries killed: 0, 1 or 2. A MAIN entry that fires out in that same cycle is not counted.
- Not defined: both ports exist but are tied to 0; no counter flops are generated.

Test Plan:
- Reset then single instruction: send ctrl_d_i=12'hA5C, data field0=32'h0000_1000, ready_e_i=1 -> next cycle valid_e_o=1, ctrl_e_o=12'hA5C, field0=32'h1000; following cycle valid_e_o=0, ctrl_e_o=0.
- Backpressure fill: ready_e_i=0, stream rd fields 3,4,5 -> rd=3 in MAIN, rd=4 in SKID, ready_d_o=0 from the next cycle, rd=5 held upstream. Raise ready_e_i -> outputs 3,4,5 on consecutive cycles with no loss or duplication.
- Flush with both entries full: flush_i=1 with valid_d_i=1 -> next cycle valid_e_o=0, ctrl_e_o=0, regs_e_o=0, ready_d_o=1; the input instruction is dropped; flush_cnt_o=2 when the macro is defined.
- Full-throughput streaming: valid_d_i=1, ready_e_i=1 for 8 cycles, pc 0x0..0x1C -> pc_e_o advances by 4 every cycle and ready_d_o stays 1.
- Async reset mid-stall: SKID state, assert rst_i between clock edges -> outputs zero immediately, without waiting for a clock edge; valid_e_o=0, ready_d_o=1.
- Counter (macro defined): hold valid_e_o=1, ready_e_i=0 for 10 cycles -> stall_cnt_o=10. Without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/id_ex_elastic_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_elastic_reg
// Brief    : Decode-to-execute valid/ready stage with a 2-entry skid buffer
//            and flush. Optional counters enabled by ID_EX_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module id_ex_elastic_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA       = 5,
    parameter int REGISTER_WIDTH = 5,
    parameter int CTRL_WIDTH     = 12
) (
    input  logic                           clk,
    input  logic                           rst_i,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_d_i,
    input  logic [3*REGISTER_WIDTH-1:0]    regs_d_i,
    input  logic [CTRL_WIDTH-1:0]          ctrl_d_i,
    input  logic                           valid_d_i,
    output logic                           ready_d_o,
    input  logic                           flush_i,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_e_o,
    output logic [3*REGISTER_WIDTH-1:0]    regs_e_o,
    output logic [CTRL_WIDTH-1:0]          ctrl_e_o,
    output logic                           valid_e_o,
    input  logic                           ready_e_i,
    output logic [31:0]                    stall_cnt_o,
    output logic [31:0]                    flush_cnt_o
);

    localparam int c_bus_w  = NUM_DATA * DATA_WIDTH;
    localparam int c_regs_w = 3 * REGISTER_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_ready;

    logic [c_bus_w-1:0]    r_main_data, r_skid_data;
    logic [c_regs_w-1:0]   r_main_regs, r_skid_regs;
    logic [CTRL_WIDTH-1:0] r_main_ctrl, r_skid_ctrl;

    logic w_valid_e;
    logic w_fire_in;
    logic w_fire_out;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clear_main;

    assign w_valid_e  = (r_state != ST_EMPTY);
    assign w_fire_in  = valid_d_i & r_ready;
    assign w_fire_out = w_valid_e & ready_e_i;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear_main     = 1'b0;
        if (flush_i) begin
            w_next_state = ST_EMPTY;
            w_clear_main = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_fire_in) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_fire_in && w_fire_out) begin
                        w_load_main_in = 1'b1;
                    end else if (w_fire_in) begin
                        w_load_skid  = 1'b1;
                        w_next_state = ST_SKID;
                    end else if (w_fire_out) begin
                        w_clear_main = 1'b1;
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // Skid is never bypassed: it always moves into MAIN first.
                    if (w_fire_out) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = ST_FULL;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                    w_clear_main = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state != ST_SKID);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_main_data <= '0;
            r_main_regs <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_regs <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= data_d_i;
                r_main_regs <= regs_d_i;
                r_main_ctrl <= ctrl_d_i;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_regs <= r_skid_regs;
                r_main_ctrl <= r_skid_ctrl;
            end else if (w_clear_main) begin
                // Bubble: control and register indices go to zero, data holds.
                r_main_regs <= '0;
                r_main_ctrl <= '0;
            end
            if (w_load_skid) begin
                r_skid_data <= data_d_i;
                r_skid_regs <= regs_d_i;
                r_skid_ctrl <= ctrl_d_i;
            end
        end
    end

    assign ready_d_o = r_ready;
    assign valid_e_o = w_valid_e;
    assign data_e_o  = r_main_data;
    assign regs_e_o  = r_main_regs;
    assign ctrl_e_o  = r_main_ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [1:0]  w_killed;

    // A MAIN entry leaving to execute in the flush cycle is not a kill.
    assign w_killed = {1'b0, (w_valid_e & ~ready_e_i)} + {1'b0, (r_state == ST_SKID)};

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_valid_e && !ready_e_i && !flush_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_i) begin
                r_flush_cnt <= r_flush_cnt + {30'd0, w_killed};
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire
